// File: rtl/resilient_ctrl_if.sv
// Handshake, error-detector and latch-control bundle of the resilient pipeline controller.
// The master side is the environment; the slave side is the controller.
interface resilient_ctrl_if;
  logic Lreq;
  logic Lack;
  logic Rreq;
  logic Rack;
  logic Err1;
  logic Err0;
  logic latch_en;
  logic sample;

  modport master (
    output Lreq, Rack, Err1, Err0,
    input  Lack, Rreq, latch_en, sample
  );

  modport slave (
    input  Lreq, Rack, Err1, Err0,
    output Lack, Rreq, latch_en, sample
  );
endinterface

// File: rtl/resilient_ctrl.sv
// Resilient bundled-data stage controller: opens the stage latch, optionally samples a
// dual-rail error detector, applies a recovery penalty on error, then hands the token right.
module resilient_ctrl #(
  parameter int CLK_CYC  = 2,
  parameter int SAMP_CYC = 1,
  parameter int ERR_CYC  = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  resilient_ctrl_if.slave  hs,
  input  logic             resil_en,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt,
  output logic             viol
);

  typedef enum logic [2:0] {
    IDLE, OPEN, SAMPLE, EVAL, PENALTY, SEND, RTZ
  } state_t;

  // Terminal counts of the three timed windows.
  localparam logic [7:0] CLK_LAST  = 8'(CLK_CYC - 1);
  localparam logic [7:0] SAMP_LAST = 8'(SAMP_CYC - 1);
  localparam logic [7:0] ERR_LAST  = 8'((ERR_CYC > 0) ? ERR_CYC - 1 : 0);

  state_t     state;
  logic [7:0] cnt;
  logic       mode;
  logic       lack_q;
  logic       lack_set;
  logic       rreq_q;
  logic       latch_q;
  logic       sample_q;

  assign hs.Lack     = lack_q;
  assign hs.Rreq     = rreq_q;
  assign hs.latch_en = latch_q;
  assign hs.sample   = sample_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      mode     <= 1'b0;
      lack_q   <= 1'b0;
      lack_set <= 1'b0;
      rreq_q   <= 1'b0;
      latch_q  <= 1'b0;
      sample_q <= 1'b0;
      err_cnt  <= '0;
      viol     <= 1'b0;
    end else begin
      lack_set <= 1'b0;

      // Left return-to-zero runs on its own, overlapping the right handshake.
      if (lack_q && !hs.Lreq) begin
        lack_q <= 1'b0;
      end else if (lack_set) begin
        lack_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (hs.Lreq && !lack_q && !rreq_q) begin
            state   <= OPEN;
            mode    <= resil_en;
            latch_q <= 1'b1;
            cnt     <= '0;
          end
        end

        OPEN: begin
          if (cnt == CLK_LAST) begin
            latch_q  <= 1'b0;
            lack_set <= 1'b1;
            cnt      <= '0;
            if (mode) begin
              state    <= SAMPLE;
              sample_q <= 1'b1;
            end else begin
              state <= SEND;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        SAMPLE: begin
          if (cnt == SAMP_LAST) begin
            sample_q <= 1'b0;
            cnt      <= '0;
            state    <= EVAL;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        EVAL: begin
          // Both rails high is a protocol violation and is handled as an error.
          if (hs.Err1) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (hs.Err0) viol <= 1'b1;
            if (ERR_CYC == 0) begin
              state <= SEND;
            end else begin
              state <= PENALTY;
              cnt   <= '0;
            end
          end else if (hs.Err0) begin
            state <= SEND;
          end
        end

        PENALTY: begin
          if (cnt == ERR_LAST) begin
            cnt   <= '0;
            state <= SEND;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        SEND: begin
          if (!rreq_q) begin
            rreq_q <= 1'b1;
          end else if (hs.Rack) begin
            rreq_q <= 1'b0;
            state  <= RTZ;
          end
        end

        RTZ: begin
          if (!hs.Rack) state <= IDLE;
        end

        default: state <= IDLE;
      endcase

      // NOTE: the last non-blocking assignment to a register in a cycle wins, so this
      // clear overrides any increment or violation set made above on the same edge.
      if (err_clr) begin
        err_cnt <= '0;
        viol    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_resilient_ctrl.sv
// Randomized scoreboard bench for resilient_ctrl: the stimulus pushes per-token expectations
// derived from the timing rules; a monitor pops and compares at each Rreq rise.
module tb_resilient_ctrl;

  localparam int CLK  = 2;
  localparam int SAMP = 1;
  localparam int ERRC = 3;

  typedef struct {
    int lat;
    int latch;
    int samp;
    int cnt8;
    int cnt2;
    bit viol;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       resil_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] err_cnt;
  logic       viol;
  logic [1:0] err_cnt2;
  logic       viol2;

  resilient_ctrl_if hs ();
  resilient_ctrl_if hs2 ();

  assign hs2.Lreq = hs.Lreq;
  assign hs2.Rack = hs.Rack;
  assign hs2.Err1 = hs.Err1;
  assign hs2.Err0 = hs.Err0;

  resilient_ctrl #(.CLK_CYC(CLK), .SAMP_CYC(SAMP), .ERR_CYC(ERRC), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .hs       (hs.slave),
    .resil_en (resil_en),
    .err_clr  (err_clr),
    .err_cnt  (err_cnt),
    .viol     (viol)
  );

  resilient_ctrl #(.CLK_CYC(CLK), .SAMP_CYC(SAMP), .ERR_CYC(ERRC), .CNT_W(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .hs       (hs2.slave),
    .resil_en (resil_en),
    .err_clr  (err_clr),
    .err_cnt  (err_cnt2),
    .viol     (viol2)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sbq[$];
  int   n_err = 0;
  bit   m_viol = 1'b0;
  bit   rack_hold = 1'b0;
  bit   rack_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic sig(input int id);
    case (id)
      0:       return hs.Lack;
      1:       return hs.Rreq;
      2:       return hs.sample;
      default: return hs.Rack;
    endcase
  endfunction

  task automatic wait_sig(input int id, input logic val, input string name);
    int k = 0;
    while (sig(id) !== val && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, int'(sig(id)), int'(val));
  endtask

  // Right-side environment: Rack mirrors Rreq one cycle later unless held low.
  initial begin : rack_drv
    hs.Rack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      hs.Rack   = rack_hold ? 1'b0 : rack_prev;
      rack_prev = hs.Rreq;
    end
  end

  // Monitor: measures each token from Lreq rise and scores it when Rreq rises.
  initial begin : monitor
    bit   in_tok;
    bit   lreq_prev, rreq_prev, lack_prev;
    int   t0, n_latch, n_samp;
    exp_t e;
    in_tok = 0; lreq_prev = 0; rreq_prev = 0; lack_prev = 0;
    t0 = 0; n_latch = 0; n_samp = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_tok = 0; lreq_prev = 0; rreq_prev = 0; lack_prev = 0;
        continue;
      end
      if (!in_tok && hs.Lreq && !lreq_prev) begin
        in_tok = 1; t0 = cyc; n_latch = 0; n_samp = 0;
      end
      if (in_tok) begin
        n_latch += int'(hs.latch_en);
        n_samp  += int'(hs.sample);
        if (hs.Lack && !lack_prev) check("lack_latency", cyc - t0, CLK + 2);
      end
      if (hs.Rreq && !rreq_prev) begin
        check("sb_nonempty", int'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          if (e.lat >= 0) check("rreq_latency", cyc - t0, e.lat);
          check("latch_cycles", n_latch, e.latch);
          check("sample_cycles", n_samp, e.samp);
          check("err_cnt", int'(err_cnt), e.cnt8);
          check("err_cnt_w2", int'(err_cnt2), e.cnt2);
          check("viol", int'(viol), int'(e.viol));
          check("viol_w2", int'(viol2), int'(e.viol));
        end
      end
      if (!hs.Rreq && rreq_prev) in_tok = 0;
      lreq_prev = hs.Lreq;
      rreq_prev = hs.Rreq;
      lack_prev = hs.Lack;
    end
  end

  // One full 4-phase token. kind: 0 = clean, 1 = error, 2 = both rails (violation).
  task automatic token(input bit mode, input int kind, input int d, input bit hold, input bit clr);
    exp_t e;
    bit   err;
    err = mode && (kind != 0);
    if (err) n_err++;
    if (mode && kind == 2) m_viol = 1'b1;
    if (mode && clr) begin
      n_err  = 0;
      m_viol = 1'b0;
    end
    e.lat   = mode ? (CLK + SAMP + 3 + d + (err ? ERRC : 0)) : (CLK + 2);
    e.latch = CLK;
    e.samp  = mode ? SAMP : 0;
    e.cnt8  = min2(n_err, 255);
    e.cnt2  = min2(n_err, 3);
    e.viol  = m_viol;
    sbq.push_back(e);

    rack_hold = hold;
    resil_en  = mode;
    hs.Lreq   = 1'b1;
    {hs.Err1, hs.Err0} = 2'($urandom_range(0, 3));
    @(posedge clk);
    #1;
    resil_en = 1'($urandom_range(0, 1));
    if (mode) begin
      wait_sig(2, 1'b1, "sample_rise");
      wait_sig(2, 1'b0, "sample_fall");
      {hs.Err1, hs.Err0} = 2'b00;
      repeat (d) begin
        @(posedge clk);
        #1;
      end
      hs.Err1 = (kind != 0);
      hs.Err0 = (kind != 1);
      err_clr = clr;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      {hs.Err1, hs.Err0} = 2'b00;
    end
    wait_sig(1, 1'b1, "rreq_rise");
    {hs.Err1, hs.Err0} = 2'b00;
    wait_sig(0, 1'b1, "lack_rise");
    hs.Lreq = 1'b0;
    @(posedge clk);
    #1;
    check("lack_fall", int'(hs.Lack), 0);
    if (hold) begin
      hs.Lreq = 1'b1;
      repeat (10) begin
        @(posedge clk);
        #1;
        check("hold_rreq", int'(hs.Rreq), 1);
        check("hold_no_accept", int'(hs.latch_en), 0);
      end
      hs.Lreq   = 1'b0;
      rack_hold = 1'b0;
    end
    wait_sig(1, 1'b0, "rreq_fall");
    wait_sig(3, 1'b0, "rack_fall");
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    hs.Lreq = 1'b0;
    hs.Err1 = 1'b0;
    hs.Err0 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", int'({hs.Lack, hs.Rreq, hs.latch_en, hs.sample, viol}), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Clean, error, and plain-mode tokens.
    token(1'b1, 0, 0, 1'b0, 1'b0);
    token(1'b1, 1, 0, 1'b0, 1'b0);
    token(1'b0, 1, 0, 1'b0, 1'b0);

    // Saturation of the narrow counter, then a clear.
    for (int i = 0; i < 4; i++) token(1'b1, 1, i % 2, 1'b0, 1'b0);
    check("cnt_pre_clr", int'(err_cnt), n_err);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    n_err = 0;
    m_viol = 1'b0;
    check("clr_err_cnt", int'(err_cnt), 0);
    check("clr_err_cnt_w2", int'(err_cnt2), 0);

    // Dual-rail violation with the right side stalled, then stickiness.
    token(1'b1, 2, 0, 1'b1, 1'b0);
    token(1'b1, 0, 1, 1'b0, 1'b0);

    // Clear coinciding with an increment and a violation.
    token(1'b1, 2, 0, 1'b0, 1'b1);

    // Reset in the middle of the recovery penalty.
    resil_en = 1'b1;
    hs.Lreq  = 1'b1;
    @(posedge clk);
    #1;
    wait_sig(2, 1'b1, "abort_sample_rise");
    wait_sig(2, 1'b0, "abort_sample_fall");
    hs.Err1 = 1'b1;
    @(posedge clk);
    #1;
    hs.Err1 = 1'b0;
    #3 rst = 1'b0;
    #1;
    check("abort_outs", int'({hs.Lack, hs.Rreq, hs.latch_en, hs.sample, viol}), 0);
    check("abort_err_cnt", int'(err_cnt), 0);
    n_err = 0;
    m_viol = 1'b0;
    hs.Lreq = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    token(1'b1, 0, 0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      bit m;
      int r, kind;
      m    = 1'($urandom_range(0, 1));
      r    = int'($urandom_range(0, 5));
      kind = (r < 3) ? 0 : ((r < 5) ? 1 : 2);
      token(m, kind, int'($urandom_range(0, 3)), 1'b0, m && ($urandom_range(0, 7) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
